// File: rtl/linebuf_window_ctrl_if.sv
// linebuf_window_ctrl_if: feature input stream, buffer-bank enables and window output stream
interface linebuf_window_ctrl_if #(
   parameter int LINE_W  = 8,
   parameter int NUM_BUF = 4
);
   localparam int CW = $clog2(LINE_W);
   localparam int BW = $clog2(NUM_BUF);
   logic               in_valid;
   logic               in_ready;
   logic [NUM_BUF-1:0] we;
   logic [CW-1:0]      waddr;
   logic               out_valid;
   logic               out_ready;
   logic [NUM_BUF-1:0] oe;
   logic [CW-1:0]      raddr;
   logic [BW-1:0]      top_buf;
   logic               frame_done;
   // feature source / MAC-array sink side
   modport master (
      output in_valid, out_ready,
      input  in_ready, we, waddr, out_valid, oe, raddr, top_buf, frame_done
   );
   // controller side
   modport slave (
      input  in_valid, out_ready,
      output in_ready, we, waddr, out_valid, oe, raddr, top_buf, frame_done
   );
endinterface

// File: rtl/linebuf_window_ctrl.sv
// linebuf_window_ctrl: round-robin line-buffer writer and KERNEL_H-row window streamer with occupancy tracking
module linebuf_window_ctrl #(
   parameter int LINE_W   = 8,
   parameter int KERNEL_H = 3,
   parameter int NUM_BUF  = 4,
   parameter int IMG_H    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   linebuf_window_ctrl_if.slave bus
);
   localparam int CW = $clog2(LINE_W);
   localparam int BW = $clog2(NUM_BUF);
   localparam int OW = $clog2(NUM_BUF + 1);
   localparam int LW = $clog2(IMG_H + 1);
   typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
   logic [BW-1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
   logic [LW-1:0] wr_line_q, wr_line_d, rd_row_q, rd_row_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          wr, rd, line_done, row_done;
   assign bus.in_ready   = (state_q != FLUSH) && (occ_q < OW'(NUM_BUF)) && (wr_line_q < LW'(IMG_H));
   assign bus.out_valid  = (state_q == STREAM) && (occ_q >= OW'(KERNEL_H));
   assign wr             = bus.in_valid && bus.in_ready && rst_n;
   assign rd             = bus.out_valid && bus.out_ready;
   assign line_done      = wr && (wr_col_q == CW'(LINE_W - 1));
   assign row_done       = rd && (rd_col_q == CW'(LINE_W - 1));
   assign bus.we         = wr ? NUM_BUF'(1) << wr_buf_q : '0;
   assign bus.waddr      = wr_col_q;
   assign bus.raddr      = rd_col_q;
   assign bus.top_buf    = rd_buf_q;
   assign bus.frame_done = state_q == FLUSH;
   for (genvar b = 0; b < NUM_BUF; b++) begin : g_oe
      assign bus.oe[b] = bus.out_valid && (((b + NUM_BUF - int'(rd_buf_q)) % NUM_BUF) < KERNEL_H);
   end
   // next-state: counters advance on handshakes; FLUSH clears the frame and drops residual lines
   always_comb begin
      state_d   = state_q;
      wr_col_d  = wr_col_q;
      wr_buf_d  = wr_buf_q;
      wr_line_d = wr_line_q;
      rd_col_d  = rd_col_q;
      rd_buf_d  = rd_buf_q;
      rd_row_d  = rd_row_q;
      occ_d     = occ_q;
      if (state_q == FLUSH) begin
         state_d   = FILL;
         wr_col_d  = '0;
         wr_buf_d  = '0;
         wr_line_d = '0;
         rd_col_d  = '0;
         rd_buf_d  = '0;
         rd_row_d  = '0;
         occ_d     = '0;
      end else begin
         if (wr) wr_col_d = line_done ? '0 : wr_col_q + 1'b1;
         if (line_done) begin
            wr_buf_d  = (wr_buf_q == BW'(NUM_BUF - 1)) ? '0 : wr_buf_q + 1'b1;
            wr_line_d = wr_line_q + 1'b1;
         end
         if (rd) rd_col_d = row_done ? '0 : rd_col_q + 1'b1;
         if (row_done) begin
            rd_buf_d = (rd_buf_q == BW'(NUM_BUF - 1)) ? '0 : rd_buf_q + 1'b1;
            rd_row_d = rd_row_q + 1'b1;
         end
         occ_d = occ_q + OW'(line_done) - OW'(row_done);
         if (state_q == FILL && occ_q >= OW'(KERNEL_H)) state_d = STREAM;
         if (row_done && rd_row_q == LW'(IMG_H - KERNEL_H)) state_d = FLUSH;
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FILL;
         wr_col_q  <= '0;
         wr_buf_q  <= '0;
         wr_line_q <= '0;
         rd_col_q  <= '0;
         rd_buf_q  <= '0;
         rd_row_q  <= '0;
         occ_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_col_q  <= wr_col_d;
         wr_buf_q  <= wr_buf_d;
         wr_line_q <= wr_line_d;
         rd_col_q  <= rd_col_d;
         rd_buf_q  <= rd_buf_d;
         rd_row_q  <= rd_row_d;
         occ_q     <= occ_d;
      end
   end
endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// tb_linebuf_window_ctrl: NUM_BUF=4 and NUM_BUF=5 controllers under shared random stimulus, checked by a feature-count model
module tb_linebuf_window_ctrl;
   localparam int LINE_W = 8;
   localparam int K      = 3;
   localparam int IMGH   = 6;
   typedef struct packed {
      logic       in_ready, out_valid, frame_done;
      logic [4:0] we, oe;
      logic [2:0] waddr, raddr, top_buf;
   } out_t;
   typedef struct packed {
      logic rst;
      out_t d0, d1;
   } exp_t;
   typedef struct {
      int fw, fr;
      bit strm, fl;
   } mdl_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b1;
   logic out_ready = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   mdl_t m0, m1;
   always #5 clk = ~clk;
   linebuf_window_ctrl_if #(.LINE_W(LINE_W), .NUM_BUF(4)) if0 ();
   linebuf_window_ctrl_if #(.LINE_W(LINE_W), .NUM_BUF(5)) if1 ();
   assign if0.in_valid  = in_valid;
   assign if0.out_ready = out_ready;
   assign if1.in_valid  = in_valid;
   assign if1.out_ready = out_ready;
   linebuf_window_ctrl #(.LINE_W(LINE_W), .KERNEL_H(K), .NUM_BUF(4), .IMG_H(IMGH)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave));
   linebuf_window_ctrl #(.LINE_W(LINE_W), .KERNEL_H(K), .NUM_BUF(5), .IMG_H(IMGH)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave));
   function automatic mdl_t idle();
      mdl_t r;
      r.fw = 0;
      r.fr = 0;
      r.strm = 1'b0;
      r.fl = 1'b0;
      return r;
   endfunction
   // fw/fr are features written/read this frame; line n lives in buffer n mod NB
   function automatic out_t predict(mdl_t m, int n, bit iv, bit rs);
      out_t o;
      int   occ;
      o = '0;
      occ = m.fw / LINE_W - m.fr / LINE_W;
      o.in_ready   = !m.fl && occ < n && m.fw < IMGH * LINE_W;
      o.out_valid  = m.strm && occ >= K;
      o.frame_done = m.fl;
      o.waddr      = 3'(m.fw % LINE_W);
      o.raddr      = 3'(m.fr % LINE_W);
      o.top_buf    = 3'((m.fr / LINE_W) % n);
      o.we         = (iv && rs && o.in_ready) ? 5'(1 << ((m.fw / LINE_W) % n)) : 5'd0;
      for (int k = 0; k < K; k++)
         o.oe = o.oe | (o.out_valid ? 5'(1 << ((m.fr / LINE_W + k) % n)) : 5'd0);
      return o;
   endfunction
   function automatic mdl_t step(mdl_t m, out_t o, bit iv, bit orr);
      mdl_t r;
      bit   rd;
      r = m;
      rd = o.out_valid && orr;
      if (m.fl) begin
         r = idle();
      end else begin
         if (iv && o.in_ready) r.fw++;
         if (rd) r.fr++;
         if (!m.strm && m.fw / LINE_W - m.fr / LINE_W >= K) r.strm = 1'b1;
         if (rd && r.fr == (IMGH - K + 1) * LINE_W) begin
            r.fl = 1'b1;
            r.strm = 1'b0;
         end
      end
      return r;
   endfunction
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
      vectors++;
      if (a !== x) begin
         miscompares++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, x, $time);
      end
   endtask
   task automatic cmp_out(input string tag, input out_t a, input out_t x, input bit rst);
      chk({tag, ".we"}, 32'(a.we), 32'(x.we));
      if (!rst) begin
         chk({tag, ".in_ready"}, 32'(a.in_ready), 32'(x.in_ready));
         chk({tag, ".out_valid"}, 32'(a.out_valid), 32'(x.out_valid));
         chk({tag, ".frame_done"}, 32'(a.frame_done), 32'(x.frame_done));
         chk({tag, ".oe"}, 32'(a.oe), 32'(x.oe));
         chk({tag, ".waddr"}, 32'(a.waddr), 32'(x.waddr));
         chk({tag, ".raddr"}, 32'(a.raddr), 32'(x.raddr));
         chk({tag, ".top_buf"}, 32'(a.top_buf), 32'(x.top_buf));
      end
   endtask
   task automatic cyc(input bit iv, input bit orr, input bit rs);
      out_t o0, o1;
      exp_t e;
      in_valid = iv;
      out_ready = orr;
      rst_n = rs;
      o0 = predict(m0, 4, iv, rs);
      o1 = predict(m1, 5, iv, rs);
      e.rst = !rs;
      e.d0 = o0;
      e.d1 = o1;
      sb.push_back(e);
      @(posedge clk);
      if (!rs) begin
         m0 = idle();
         m1 = idle();
      end else begin
         m0 = step(m0, o0, iv, orr);
         m1 = step(m1, o1, iv, orr);
      end
      #1;
   endtask
   initial begin
      m0 = idle();
      m1 = idle();
      @(posedge clk);
      #1;
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      repeat (40) cyc(1'b1, 1'b0, 1'b1);
      repeat (8) cyc(1'b0, 1'b1, 1'b1);
      repeat (200) cyc(1'b1, 1'b1, 1'b1);
      repeat (1500) cyc($urandom_range(99) < 70, $urandom_range(99) < 60, 1'b1);
      cyc(1'b1, 1'b1, 1'b0);
      repeat (400) cyc($urandom_range(99) < 80, $urandom_range(99) < 70, 1'b1);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
   // monitor: pops the expected outputs for the current cycle and compares both controllers
   initial begin
      out_t a0, a1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            a0.in_ready = if0.in_ready;
            a0.out_valid = if0.out_valid;
            a0.frame_done = if0.frame_done;
            a0.we = 5'(if0.we);
            a0.oe = 5'(if0.oe);
            a0.waddr = if0.waddr;
            a0.raddr = if0.raddr;
            a0.top_buf = 3'(if0.top_buf);
            a1.in_ready = if1.in_ready;
            a1.out_valid = if1.out_valid;
            a1.frame_done = if1.frame_done;
            a1.we = if1.we;
            a1.oe = if1.oe;
            a1.waddr = if1.waddr;
            a1.raddr = if1.raddr;
            a1.top_buf = if1.top_buf;
            cmp_out("nb4", a0, e.d0, e.rst);
            cmp_out("nb5", a1, e.d1, e.rst);
         end
      end
   end
endmodule
